alu_op_issue: RTL

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

---
 rtl/alu_op_issue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes RV32 instruction fields into a 4-bit ALU operation code and queues the
// result, with its destination tag, in a 2-entry FIFO for a downstream ALU.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   in_valid_i      decoded instruction fields present this cycle
//   in_ready_o      block accepts a field set this cycle (registered: FIFO not full)
//   opcode_i        instruction bits [6:0]
//   funct3_i        instruction bits [14:12]
//   funct7b5_i      instruction bit 30
//   tag_i           destination register index, carried through unchanged
//   out_valid_o     head entry valid
//   out_ready_i     consumer takes the head entry this cycle
//   ALU_Operation_o ALU operation code of the head entry
//   tag_o           tag of the head entry
//   illegal_o       head entry came from an unsupported encoding
//   illegal_cnt_o   saturating count of accepted illegal entries (ALU_OP_ILLEGAL_CNT_EN only)
//
// Optional feature macro: ALU_OP_ILLEGAL_CNT_EN adds the illegal_cnt_o port and its counter.

module alu_op_issue (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [4:0] tag_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] ALU_Operation_o,
  output logic [4:0] tag_o,
  output logic       illegal_o
`ifdef ALU_OP_ILLEGAL_CNT_EN
  ,
  output logic [7:0] illegal_cnt_o
`endif
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0111;
  localparam logic [3:0] OpOri = 4'b1000;
  localparam logic [3:0] OpLui = 4'b1001;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  // Entry layout: {op[3:0], tag[4:0], illegal}
  logic [3:0] dec_op;
  logic       dec_ill;
  logic [9:0] dec_entry;
  logic [9:0] head_q, head_d, tail_q, tail_d;
  state_e     state_q, state_d;
  logic       accept, pop;

  always_comb begin
    dec_op  = OpAdd;
    dec_ill = 1'b0;
    case (opcode_i)
      7'b0110011: begin
        case (funct3_i)
          3'b000:  dec_op = funct7b5_i ? OpSub : OpAdd;
          3'b100:  dec_op = OpXor;
          3'b110:  dec_op = OpOr;
          3'b111:  dec_op = OpAnd;
          3'b001:  if (!funct7b5_i) dec_op = OpSll; else dec_ill = 1'b1;
          3'b101:  if (!funct7b5_i) dec_op = OpSrl; else dec_ill = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        case (funct3_i)
          3'b000:  dec_op = OpAdd;
          3'b100:  dec_op = OpXor;
          3'b110:  dec_op = OpOri;
          3'b111:  dec_op = OpAnd;
          3'b001:  if (!funct7b5_i) dec_op = OpSll; else dec_ill = 1'b1;
          3'b101:  if (!funct7b5_i) dec_op = OpSrl; else dec_ill = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0110111: dec_op = OpLui;
      7'b0000011: dec_op = OpAdd;
      7'b0100011: dec_op = OpAdd;
      7'b1100011: begin
        if (funct3_i == 3'b000 || funct3_i == 3'b001) dec_op = OpSub;
        else dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // Unsupported encodings always report ADD alongside the illegal flag.
    if (dec_ill) dec_op = OpAdd;
  end

  assign dec_entry = {dec_op, tag_i, dec_ill};

  assign in_ready_o  = (state_q != StTwo);
  assign out_valid_o = (state_q != StEmpty);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = dec_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = dec_entry;
        end else if (accept) begin
          tail_d  = dec_entry;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign ALU_Operation_o = head_q[9:6];
  assign tag_o           = head_q[5:1];
  assign illegal_o       = head_q[0];

`ifdef ALU_OP_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt_q <= '0;
    end else if (accept && dec_ill && (illegal_cnt_q != 8'hff)) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule
